vram_port_arbiter: RTL

Shares one QSPI serial-SRAM controller port (the VRAM M23LC1024 behind `hack_soc`) between two requesters: the display refresh fetcher (high priority) and the CPU memory-mapped screen path (low priority, anti-starvation guaranteed). It sits between the requesters and the single-transaction SPI SRAM controller. It issues one 16-bit word transaction at a time, returns read data to the granted requester, and recovers from a hung controller through a watchdog.

---
 rtl/hack_soc_pkg.sv | 18 +
 rtl/arb_watchdog.sv | 31 +++
 rtl/vram_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hack_soc_pkg.sv
// Shared definitions for the hack_soc memory-port arbiters and their helpers.
package hack_soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic GNT_DISP = 1'b0;
    localparam logic GNT_CPU  = 1'b1;

    localparam int DEF_TIMEOUT        = 255;
    localparam int DEF_MAX_DISP_BURST = 4;
    localparam int WD_WIDTH           = 8;

endpackage

// File: rtl/arb_watchdog.sv
// Loadable down-counter watchdog: start loads, clear disarms, expired flags an
// armed counter that has reached zero.
module arb_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    input  logic             clear,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;
    logic             active;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= load;
            active <= 1'b1;
        end else if (active && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = active && (cnt == '0);

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter in front of the single-transaction VRAM SPI controller:
// display has priority, CPU is guaranteed a slot after a bounded display burst.
module vram_port_arbiter
    import hack_soc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_DISP_BURST = DEF_MAX_DISP_BURST,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_ack,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  mem_start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  timeout_err
);

    localparam int SW = (MAX_DISP_BURST < 1) ? 1 : $clog2(MAX_DISP_BURST + 1);
    localparam logic [SW-1:0]       BURST_MAX = SW'(MAX_DISP_BURST);
    localparam logic [WD_WIDTH-1:0] WD_LOAD   = WD_WIDTH'(TIMEOUT);

    arb_state_t    state, state_nxt;
    logic          gnt;
    logic [SW-1:0] starve_cnt;
    logic          grant, pick, wd_start, wd_clear, wd_expired, finish, abort;

    arb_watchdog #(.WIDTH(WD_WIDTH)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .start   (wd_start),
        .load    (WD_LOAD),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick      = GNT_DISP;
        wd_start  = 1'b0;
        wd_clear  = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (disp_req || cpu_req) begin
                    grant     = 1'b1;
                    pick      = (cpu_req && (!disp_req || starve_cnt == BURST_MAX)) ? GNT_CPU : GNT_DISP;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion beats a coincident watchdog expiry.
                if (mem_done) begin
                    finish    = 1'b1;
                    wd_clear  = 1'b1;
                    state_nxt = ST_RESP;
                end else if (wd_expired) begin
                    abort     = 1'b1;
                    wd_clear  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt         <= GNT_DISP;
            starve_cnt  <= '0;
            mem_start   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            disp_ack    <= 1'b0;
            disp_rdata  <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            mem_start <= grant;
            disp_ack  <= (finish || abort) && (gnt == GNT_DISP);
            cpu_ack   <= (finish || abort) && (gnt == GNT_CPU);
            if (grant) begin
                gnt <= pick;
                if (pick == GNT_CPU) begin
                    mem_we     <= cpu_we;
                    mem_addr   <= cpu_addr;
                    mem_wdata  <= cpu_wdata;
                    starve_cnt <= '0;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= disp_addr;
                    mem_wdata <= '0;
                    if (cpu_req && starve_cnt != BURST_MAX)
                        starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (finish || abort) begin
                if (gnt == GNT_DISP) disp_rdata <= finish ? mem_rdata : '0;
                else                 cpu_rdata  <= finish ? mem_rdata : '0;
            end
            if (abort) timeout_err <= 1'b1;
        end
    end

endmodule
